// File: rtl/button_events.sv
// Turns a debounced button level into single-cycle press/release/click/long/repeat
// pulses plus a registered held level.
module button_events #(
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int CNT_W         = 26
) (
    input  logic clk,
    input  logic reset,
    input  logic clean,
    output logic down,
    output logic up,
    output logic click,
    output logic long_press,
    output logic auto_repeat,
    output logic held
);

    // state | meaning
    // ARM   | after reset; waiting for the button to be seen released
    // IDLE  | released, ready to accept a press
    // SHORT | pressed, long threshold not yet reached
    // LONG  | pressed past the long threshold, auto-repeating
    typedef enum logic [1:0] {
        ARM   = 2'd0,
        IDLE  = 2'd1,
        SHORT = 2'd2,
        LONG  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    logic down_nxt;
    logic up_nxt;
    logic click_nxt;
    logic long_nxt;
    logic repeat_nxt;
    logic held_nxt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ARM;
            cnt         <= '0;
            down        <= 1'b0;
            up          <= 1'b0;
            click       <= 1'b0;
            long_press  <= 1'b0;
            auto_repeat <= 1'b0;
            held        <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            down        <= down_nxt;
            up          <= up_nxt;
            click       <= click_nxt;
            long_press  <= long_nxt;
            auto_repeat <= repeat_nxt;
            held        <= held_nxt;
        end
    end

    // Counter is reloaded on every exit and at each threshold, so it never wraps.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ARM: begin
                cnt_nxt = '0;
                if (!clean) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                cnt_nxt = '0;
                if (clean) begin
                    state_nxt = SHORT;
                end
            end
            SHORT: begin
                if (!clean) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == LONG_LAST) begin
                    state_nxt = LONG;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            LONG: begin
                if (!clean) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == REPEAT_LAST) begin
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ARM;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Release takes priority over a threshold hit on the same edge.
    always_comb begin
        down_nxt   = 1'b0;
        up_nxt     = 1'b0;
        click_nxt  = 1'b0;
        long_nxt   = 1'b0;
        repeat_nxt = 1'b0;
        held_nxt   = (state_nxt == SHORT) || (state_nxt == LONG);
        case (state)
            IDLE: begin
                down_nxt = clean;
            end
            SHORT: begin
                up_nxt    = !clean;
                click_nxt = !clean;
                long_nxt  = clean && (cnt == LONG_LAST);
            end
            LONG: begin
                up_nxt     = !clean;
                repeat_nxt = clean && (cnt == REPEAT_LAST);
            end
            default: begin
                down_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_button_events.sv
// Randomized and directed stimulus for button_events, checked every cycle against
// an event model based on press age counted in edges.
module tb_button_events;

    localparam int L = 8;
    localparam int R = 4;
    localparam int W = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic clean = 1'b1;
    logic down, up, click, long_press, auto_repeat, held;

    button_events #(
        .LONG_CYCLES  (L),
        .REPEAT_CYCLES(R),
        .CNT_W        (W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clean      (clean),
        .down       (down),
        .up         (up),
        .click      (click),
        .long_press (long_press),
        .auto_repeat(auto_repeat),
        .held       (held)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // model: armed = released seen since reset; age = edges since the accepting edge
    bit armed    = 1'b0;
    bit pressing = 1'b0;
    int age      = 0;
    logic e_down, e_up, e_click, e_long, e_rep, e_held;

    task automatic check(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
        end
    endtask

    task automatic step(input logic c, input logic r);
        @(negedge clk);
        clean = c;
        reset = r;
        @(posedge clk);
        e_down = 1'b0; e_up = 1'b0; e_click = 1'b0; e_long = 1'b0; e_rep = 1'b0;
        if (!r) begin
            armed    = 1'b0;
            pressing = 1'b0;
        end else if (!armed) begin
            if (!c) armed = 1'b1;
        end else if (!pressing) begin
            if (c) begin
                pressing = 1'b1;
                age      = 0;
                e_down   = 1'b1;
            end
        end else begin
            age++;
            if (!c) begin
                pressing = 1'b0;
                e_up     = 1'b1;
                e_click  = (age <= L);
            end else begin
                e_long = (age == L);
                e_rep  = (age > L) && ((age - L) % R == 0);
            end
        end
        e_held = pressing;
        #1;
        check("down", down, e_down);
        check("up", up, e_up);
        check("click", click, e_click);
        check("long_press", long_press, e_long);
        check("auto_repeat", auto_repeat, e_rep);
        check("held", held, e_held);
        check("exclusive", logic'((int'(click) + int'(long_press) + int'(auto_repeat)) > 1), 1'b0);
        check("down_up_overlap", down & up, 1'b0);
    endtask

    task automatic press(input int hi, input int lo);
        for (int i = 0; i < hi; i++) step(1'b1, 1'b1);
        for (int i = 0; i < lo; i++) step(1'b0, 1'b1);
    endtask

    initial begin
        // held through reset, then released reset: silence until a low is seen
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 5; i++)  step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        press(1, 3);
        // short, long with repeats, both sides of the threshold edge
        press(3, 3);
        press(20, 3);
        press(8, 3);
        press(9, 3);
        // reset mid-LONG with button still held
        press(12, 0);
        step(1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1);
        press(0, 1);
        press(2, 2);
        // back-to-back presses separated by one low cycle
        press(2, 1);
        press(2, 3);
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 19) == 0) begin
                for (int k = 0; k < int'($urandom_range(1, 2)); k++)
                    step(logic'($urandom_range(0, 1)), 1'b0);
            end
            press(int'($urandom_range(1, 30)), int'($urandom_range(1, 4)));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
